raxi_fifo: RTL and testbench
============================

# raxi_fifo

Parametrised rAXI stream FIFO, successor to the plain rAXI signal bundle. It buffers the full beat (data, user, id, first, last, keep) between a slave-side producer and a master-side consumer using a valid/ready handshake. It runs in cut-through or packet (store-and-forward) mode. It sits between rAXI producers and consumers in the SDR datapath to absorb back-pressure and re-time frames.

## Interface
- DW, 16: data width, bits.
- UW, 1: user width, bits.
- IW, 1: id width, bits.
- DEPTH, 16: entries; power of two, at least 2.
- PKT_MODE, 0: 0 = cut-through, 1 = store-and-forward on `last`.
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_valid, s_first, s_last, s_keep  in  1 each  input beat qualifiers.
- s_data  in  DW  input data.
- s_user  in  UW  input user sideband.
- s_id  in  IW  input id.
- s_ready  out  1  FIFO can accept a beat.
- m_valid, m_first, m_last, m_keep  out  1 each  output beat qualifiers.
- m_data  out  DW  output data.
- m_user  out  UW  output user sideband.
- m_id  out  IW  output id.
- m_ready  in  1  consumer accepts the beat.
- level  out  $clog2(DEPTH)+1  number of stored beats.

## Operation
- Write: accepted when s_valid && s_ready. The whole beat is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
- Read: accepted when m_valid && m_ready. rd_ptr increments modulo DEPTH.
- Pointers are $clog2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
- empty = (wr_ptr == rd_ptr).
- full = address bits equal and MSBs differ.
- level = wr_ptr - rd_ptr, modulo 2^(addr+1).
- s_ready = !full && !reset.
  - No write-through when full: a simultaneous read on a full FIFO does not let a write in that cycle.
- Presentation is first-word fall-through: m_* shows mem[rd_ptr].
- Payload outputs (m_data, m_user, m_id, m_first, m_last, m_keep) are forced to 0 whenever m_valid = 0.
- Packet mode, pkt_cnt (0..DEPTH):
  - Increments on a write with s_last = 1.
  - Decrements on a read with m_last = 1.
  - Both in the same cycle leave it unchanged.
- Packet mode, drain flag:
  - Set on a read with m_last = 0.
  - Cleared on a read with m_last = 1.
- m_valid:
  - Cut-through mode: !empty.
  - Packet mode: !empty && (pkt_cnt != 0 || full || drain).
- Oversize packets: if the FIFO fills with no complete packet stored, output is forced. Drain then keeps m_valid asserted until that packet's `last` leaves, except that m_valid drops while empty mid-packet.
- No checking of first/last framing. Beats are passed verbatim, including keep = 0 beats.

## Timing
- Reset values (cycle after reset sampled high):
  - m_valid = 0, s_ready = 0 while reset is high, level = 0, all payload outputs 0.
  - pointers, pkt_cnt and drain cleared.
- s_ready = 1 in the first cycle after reset deasserts.
- Reset mid-operation: contents are discarded on the next edge and no beat is emitted afterwards. Any partial packet is lost.
- Cut-through latency: a beat written at edge N is presented with m_valid = 1 from edge N onward, i.e. valid in cycle N+1. No combinational s→m path.
- Packet mode latency: the first beat of a packet is presented in the cycle after its `last` beat is written.
- Throughput: one beat per cycle with simultaneous read and write, including at level = DEPTH-1 and level = 1.
- Once m_valid = 1, it stays asserted with stable payload until m_ready, except on reset.
- level is updated on the same edge as the pointers.

## Test plan
- Reset then idle:
  - Required: s_ready = 0 during reset and 1 one cycle after; m_valid = 0; level = 0; payload outputs 0.
- Cut-through, DEPTH=16, m_ready = 0, write 16 beats with data 0..15:
  - Required: s_ready drops after beat 16 and level = 16.
  - Then raise m_ready: data 0..15 out in order, one per cycle, with user/id/first/last/keep preserved.
- Continuous stream, s_valid = m_ready = 1 for 100 beats:
  - Required: level stays at 1 after the first beat and 100 beats emerge back-to-back.
  - Then toggle m_ready randomly: no loss or duplication, and pointers wrap correctly.
- PKT_MODE=1, write a 5-beat packet (first on beat 0, last on beat 4), m_ready = 1:
  - Required: m_valid = 0 until the cycle after beat 4 is written, then 5 consecutive beats.
  - Two packets back-to-back: pkt_cnt peaks at 2 and returns to 0.
- PKT_MODE=1, DEPTH=16, write a 20-beat packet:
  - Required: the FIFO fills and forced drain starts.
  - All 20 beats are delivered in order, and m_valid stays high through beat 19 when input keeps pace.
- Assert reset with level = 7 mid-packet:
  - Required: next cycle level = 0, m_valid = 0; after reset, a fresh 3-beat packet passes intact.

Source files
------------

// File: rtl/raxi_fifo.sv
// raxi_fifo: rAXI stream FIFO buffering full beats (data, user, id, first, last, keep)
// with first-word fall-through presentation in cut-through or store-and-forward mode.
module raxi_fifo #(
   parameter int DW       = 16,
   parameter int UW       = 1,
   parameter int IW       = 1,
   parameter int DEPTH    = 16,
   parameter int PKT_MODE = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     s_valid,
   input  logic                     s_first,
   input  logic                     s_last,
   input  logic                     s_keep,
   input  logic [DW-1:0]            s_data,
   input  logic [UW-1:0]            s_user,
   input  logic [IW-1:0]            s_id,
   output logic                     s_ready,
   output logic                     m_valid,
   output logic                     m_first,
   output logic                     m_last,
   output logic                     m_keep,
   output logic [DW-1:0]            m_data,
   output logic [UW-1:0]            m_user,
   output logic [IW-1:0]            m_id,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [DW-1:0] data;
      logic [UW-1:0] user;
      logic [IW-1:0] id;
      logic          first;
      logic          last;
      logic          keep;
   } beat_t;

   beat_t       mem [DEPTH];
   beat_t       s_beat;
   beat_t       head;
   beat_t       m_beat;
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] pkt_cnt;
   logic        drain;
   logic        empty;
   logic        full;
   logic        wr_en;
   logic        rd_en;
   logic        pkt_in;
   logic        pkt_out;

   assign s_beat  = {s_data, s_user, s_id, s_first, s_last, s_keep};
   assign head    = mem[rd_ptr[AW-1:0]];

   // The extra pointer MSB separates a full FIFO from an empty one.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign level   = wr_ptr - rd_ptr;

   // No write-through on full: a same-cycle read does not free a slot for the writer.
   assign s_ready = !full && !reset;
   assign wr_en   = s_valid && s_ready;

   // Packet mode holds output back until a whole packet is stored, or the FIFO is
   // full with none stored, in which case drain keeps the oversize packet flowing.
   always_comb begin
      if (PKT_MODE != 0) begin
         m_valid = !empty && ((pkt_cnt != '0) || full || drain);
      end else begin
         m_valid = !empty;
      end
   end

   assign rd_en   = m_valid && m_ready;
   assign m_beat  = m_valid ? head : '0;
   assign m_data  = m_beat.data;
   assign m_user  = m_beat.user;
   assign m_id    = m_beat.id;
   assign m_first = m_beat.first;
   assign m_last  = m_beat.last;
   assign m_keep  = m_beat.keep;

   assign pkt_in  = wr_en && s_last;
   assign pkt_out = rd_en && m_last;

   // NOTE: storage is deliberately not reset; pointers alone define which entries are
   // valid, and leaving the array out of reset lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= s_beat;
      end
   end

   // NOTE: all state below uses non-blocking assignments so every register samples
   // the pre-edge values of the others regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         pkt_cnt <= '0;
         drain   <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
            drain  <= !m_last;
         end
         case ({pkt_in, pkt_out})
            2'b10:   pkt_cnt <= pkt_cnt + (AW+1)'(1);
            2'b01:   pkt_cnt <= pkt_cnt - (AW+1)'(1);
            default: pkt_cnt <= pkt_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_raxi_fifo.sv
// Directed bench for raxi_fifo: one cut-through and one packet-mode instance,
// each compared against a queue of the beats the bench itself has pushed.
module tb_raxi_fifo;

   localparam int DEPTH = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // Beat vector layout: {data[15:0], user, id, first, last, keep}
   logic [20:0] ct_sb = '0, pk_sb = '0;
   logic [20:0] ct_mb, pk_mb;
   logic        ct_s_valid = 1'b0, pk_s_valid = 1'b0;
   logic        ct_m_ready = 1'b0, pk_m_ready = 1'b0;
   logic        ct_s_ready, pk_s_ready, ct_m_valid, pk_m_valid;
   logic        ct_m_first, ct_m_last, ct_m_keep, pk_m_first, pk_m_last, pk_m_keep;
   logic [15:0] ct_m_data, pk_m_data;
   logic [0:0]  ct_m_user, ct_m_id, pk_m_user, pk_m_id;
   logic [4:0]  ct_level, pk_level;

   assign ct_mb = {ct_m_data, ct_m_user, ct_m_id, ct_m_first, ct_m_last, ct_m_keep};
   assign pk_mb = {pk_m_data, pk_m_user, pk_m_id, pk_m_first, pk_m_last, pk_m_keep};

   raxi_fifo #(.DW(16), .UW(1), .IW(1), .DEPTH(DEPTH), .PKT_MODE(0)) u_ct (
      .clk(clk), .reset(reset),
      .s_valid(ct_s_valid), .s_first(ct_sb[2]), .s_last(ct_sb[1]), .s_keep(ct_sb[0]),
      .s_data(ct_sb[20:5]), .s_user(ct_sb[4]), .s_id(ct_sb[3]), .s_ready(ct_s_ready),
      .m_valid(ct_m_valid), .m_first(ct_m_first), .m_last(ct_m_last), .m_keep(ct_m_keep),
      .m_data(ct_m_data), .m_user(ct_m_user), .m_id(ct_m_id), .m_ready(ct_m_ready),
      .level(ct_level)
   );

   raxi_fifo #(.DW(16), .UW(1), .IW(1), .DEPTH(DEPTH), .PKT_MODE(1)) u_pk (
      .clk(clk), .reset(reset),
      .s_valid(pk_s_valid), .s_first(pk_sb[2]), .s_last(pk_sb[1]), .s_keep(pk_sb[0]),
      .s_data(pk_sb[20:5]), .s_user(pk_sb[4]), .s_id(pk_sb[3]), .s_ready(pk_s_ready),
      .m_valid(pk_m_valid), .m_first(pk_m_first), .m_last(pk_m_last), .m_keep(pk_m_keep),
      .m_data(pk_m_data), .m_user(pk_m_user), .m_id(pk_m_id), .m_ready(pk_m_ready),
      .level(pk_level)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [20:0] ct_q[$];
   logic [20:0] pk_q[$];
   int          ct_pops = 0;
   int          pk_pops = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [20:0] mk(input int i, input logic f, input logic l);
      logic [15:0] d;
      d = i[15:0];
      return {d, d[0], d[1], f, l, d[2]};
   endfunction

   // One cycle on the cut-through instance; called at a falling edge, returns at the next.
   task automatic step_ct(input logic sv, input logic [20:0] b, input logic mr, output logic acc);
      int sz;
      ct_s_valid = sv;
      ct_sb      = b;
      ct_m_ready = mr;
      #1;
      sz = ct_q.size();
      check("ct_s_ready", 32'(ct_s_ready), 32'(sz < DEPTH));
      check("ct_m_valid", 32'(ct_m_valid), 32'(sz != 0));
      check("ct_level", 32'(ct_level), 32'(sz));
      acc = sv && (sz < DEPTH);
      if (sz == 0) begin
         check("ct_idle_payload", 32'(ct_mb), 32'd0);
      end else if (mr) begin
         check("ct_beat", 32'(ct_mb), 32'(ct_q[0]));
         void'(ct_q.pop_front());
         ct_pops++;
      end
      if (acc) ct_q.push_back(b);
      @(negedge clk);
   endtask

   // One cycle on the packet-mode instance with a hand-derived expected m_valid.
   task automatic step_pk(input logic sv, input logic [20:0] b, input logic mr,
                          input logic exp_mv, output logic acc);
      int sz;
      pk_s_valid = sv;
      pk_sb      = b;
      pk_m_ready = mr;
      #1;
      sz = pk_q.size();
      check("pk_s_ready", 32'(pk_s_ready), 32'(sz < DEPTH));
      check("pk_m_valid", 32'(pk_m_valid), 32'(exp_mv));
      check("pk_level", 32'(pk_level), 32'(sz));
      acc = sv && (sz < DEPTH);
      if (!exp_mv) begin
         check("pk_idle_payload", 32'(pk_mb), 32'd0);
      end else if (mr && sz != 0) begin
         check("pk_beat", 32'(pk_mb), 32'(pk_q[0]));
         void'(pk_q.pop_front());
         pk_pops++;
      end
      if (acc) pk_q.push_back(b);
      @(negedge clk);
   endtask

   initial begin
      logic acc;
      int   idx;
      int   pushed;
      int   base;

      // Reset then idle
      repeat (2) @(negedge clk);
      #1;
      check("rst_ct_s_ready", 32'(ct_s_ready), 32'd0);
      check("rst_pk_s_ready", 32'(pk_s_ready), 32'd0);
      check("rst_ct_m_valid", 32'(ct_m_valid), 32'd0);
      check("rst_pk_m_valid", 32'(pk_m_valid), 32'd0);
      check("rst_ct_level", 32'(ct_level), 32'd0);
      check("rst_ct_payload", 32'(ct_mb), 32'd0);
      check("rst_pk_payload", 32'(pk_mb), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_rst_ct_s_ready", 32'(ct_s_ready), 32'd1);
      check("post_rst_pk_s_ready", 32'(pk_s_ready), 32'd1);
      @(negedge clk);

      // Cut-through fill to 16 with the consumer stalled
      for (int i = 0; i < 16; i++) step_ct(1'b1, mk(i, i == 0, i == 15), 1'b0, acc);
      #1;
      check("ct_full_s_ready", 32'(ct_s_ready), 32'd0);
      check("ct_full_level", 32'(ct_level), 32'd16);
      check("ct_full_head", 32'(ct_m_data), 32'd0);
      @(negedge clk);
      // Read on full with a write offered: the write must be refused
      step_ct(1'b1, mk(99, 1'b0, 1'b0), 1'b1, acc);
      check("ct_no_write_through", 32'(ct_level), 32'd15);
      for (int i = 0; i < 15; i++) step_ct(1'b0, '0, 1'b1, acc);
      check("ct_fill_pops", 32'(ct_pops), 32'd16);
      step_ct(1'b0, '0, 1'b1, acc);

      // Continuous stream of 100 beats
      base = ct_pops;
      for (int i = 0; i < 100; i++) step_ct(1'b1, mk(i + 200, i == 0, i == 99), 1'b1, acc);
      step_ct(1'b0, '0, 1'b1, acc);
      check("ct_stream_pops", 32'(ct_pops - base), 32'd100);

      // Random back-pressure on both sides
      base   = ct_pops;
      pushed = 0;
      idx    = 0;
      for (int i = 0; i < 300; i++) begin
         step_ct(1'($urandom_range(0, 3) != 0), mk(idx + 1000, 1'b0, 1'b0),
                 1'($urandom_range(0, 1)), acc);
         if (acc) begin
            idx++;
            pushed++;
         end
      end
      for (int i = 0; i < 40 && ct_q.size() != 0; i++) step_ct(1'b0, '0, 1'b1, acc);
      check("ct_random_drained", 32'(ct_q.size()), 32'd0);
      check("ct_random_pops", 32'(ct_pops - base), 32'(pushed));
      step_ct(1'b0, '0, 1'b0, acc);

      // Packet mode: one 5-beat packet
      for (int i = 0; i < 5; i++) step_pk(1'b1, mk(i + 50, i == 0, i == 4), 1'b1, 1'b0, acc);
      for (int i = 0; i < 5; i++) step_pk(1'b0, '0, 1'b1, 1'b1, acc);
      step_pk(1'b0, '0, 1'b1, 1'b0, acc);
      check("pk_single_pops", 32'(pk_pops), 32'd5);

      // Two 3-beat packets back-to-back with the consumer stalled
      for (int i = 0; i < 3; i++) step_pk(1'b1, mk(i + 60, i == 0, i == 2), 1'b0, 1'b0, acc);
      for (int i = 0; i < 3; i++) step_pk(1'b1, mk(i + 70, i == 0, i == 2), 1'b0, 1'b1, acc);
      check("pk_cnt_peak", 32'(u_pk.pkt_cnt), 32'd2);
      for (int i = 0; i < 6; i++) step_pk(1'b0, '0, 1'b1, 1'b1, acc);
      check("pk_cnt_return", 32'(u_pk.pkt_cnt), 32'd0);
      step_pk(1'b0, '0, 1'b1, 1'b0, acc);
      check("pk_pair_pops", 32'(pk_pops), 32'd11);

      // Oversize 20-beat packet: forced output at full, drain carries it through
      base = pk_pops;
      idx  = 0;
      for (int st = 0; st <= 36; st++) begin
         step_pk(1'(idx < 20), mk(idx + 300, idx == 0, idx == 19), 1'b1,
                 1'(st >= 16 && st <= 35), acc);
         if (acc) idx++;
      end
      check("pk_oversize_written", 32'(idx), 32'd20);
      check("pk_oversize_pops", 32'(pk_pops - base), 32'd20);

      // Reset mid-packet at level 7, then a fresh 3-beat packet
      for (int i = 0; i < 7; i++) step_pk(1'b1, mk(i + 500, i == 0, 1'b0), 1'b0, 1'b0, acc);
      pk_s_valid = 1'b0;
      reset      = 1'b1;
      #1;
      check("midrst_level_before", 32'(pk_level), 32'd7);
      check("midrst_s_ready", 32'(pk_s_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      pk_q.delete();
      #1;
      check("midrst_level", 32'(pk_level), 32'd0);
      check("midrst_m_valid", 32'(pk_m_valid), 32'd0);
      check("midrst_payload", 32'(pk_mb), 32'd0);
      @(negedge clk);
      base = pk_pops;
      for (int i = 0; i < 3; i++) step_pk(1'b1, mk(i + 600, i == 0, i == 2), 1'b1, 1'b0, acc);
      for (int i = 0; i < 3; i++) step_pk(1'b0, '0, 1'b1, 1'b1, acc);
      step_pk(1'b0, '0, 1'b1, 1'b0, acc);
      check("midrst_fresh_pops", 32'(pk_pops - base), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
